// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the key scheduler slice.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int AES_BYTE   = 8;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } ks_state_t;

  function automatic logic [AES_BYTE-1:0] xtime(input logic [AES_BYTE-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [AES_BYTE-1:0] gfMul(input logic [AES_BYTE-1:0] a,
                                                input logic [AES_BYTE-1:0] b);
    logic [AES_BYTE-1:0] p;
    logic [AES_BYTE-1:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < AES_BYTE; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/key_round.sv
// One AES-128 key-expansion round: four words in, four words out.
module key_round
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);

  word_t w_col0, w_col1, w_col2, w_col3;
  word_t w_rot, w_sub, w_t;
  word_t w_new0, w_new1, w_new2, w_new3;

  assign w_col0 = i_key[31:0];
  assign w_col1 = i_key[63:32];
  assign w_col2 = i_key[95:64];
  assign w_col3 = i_key[127:96];

  // byte 0 sits in the LSB, so RotWord moves byte 0 up to the top
  assign w_rot = {w_col3[7:0], w_col3[31:8]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    s_box u_sbox (
      .i_byte(w_rot[8*g +: 8]),
      .o_byte(w_sub[8*g +: 8])
    );
  end

  assign w_t    = w_sub ^ {24'h0, i_rcon};
  assign w_new0 = w_col0 ^ w_t;
  assign w_new1 = w_col1 ^ w_new0;
  assign w_new2 = w_col2 ^ w_new1;
  assign w_new3 = w_col3 ^ w_new2;
  assign o_key  = {w_new3, w_new2, w_new1, w_new0};

endmodule

// File: rtl/s_box.sv
// AES forward S-box computed as GF(2^8) inverse followed by the affine map.
module s_box
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // x^254 is the multiplicative inverse; it maps 0 to 0 as the S-box requires
  function automatic logic [7:0] sboxCalc(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign o_byte = sboxCalc(i_byte);

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key scheduler: one round key per clock, 11 keys stored,
// registered indexed read port for the round datapath.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [DATA_WIDTH-1:0] key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  keys_valid,
  input  logic [IDX_WIDTH-1:0]  rk_idx,
  output logic [DATA_WIDTH-1:0] rk_out
);

  localparam logic [IDX_WIDTH-1:0] LAST_ROUND = IDX_WIDTH'(NUM_ROUNDS);

  ks_state_t             r_state;
  ks_state_t             w_stateNext;
  logic [IDX_WIDTH-1:0]  r_round;
  logic [7:0]            r_rcon;
  logic [DATA_WIDTH-1:0] r_work;
  logic [DATA_WIDTH-1:0] r_rk [0:NUM_ROUNDS];
  logic [DATA_WIDTH-1:0] r_rkOut;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] w_next;
  logic                  w_accept;

  key_round u_key_round (
    .i_key (r_work),
    .i_rcon(r_rcon),
    .o_key (w_next)
  );

  assign w_accept = key_valid && key_ready;
  assign done     = r_done;
  assign rk_out   = r_rkOut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    key_ready   = 1'b0;
    busy        = 1'b0;
    keys_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) w_stateNext = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (r_round == LAST_ROUND) w_stateNext = READY;
      end
      READY: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
        if (key_valid) w_stateNext = EXPAND;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Expansion datapath; the read port samples storage before this edge's write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= '0;
      r_rcon  <= 8'h01;
      r_work  <= '0;
      r_done  <= 1'b0;
      r_rkOut <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, READY: begin
          if (w_accept) begin
            r_rk[0] <= key_in;
            r_work  <= key_in;
            r_round <= IDX_WIDTH'(1);
            r_rcon  <= 8'h01;
          end
        end
        EXPAND: begin
          r_rk[r_round] <= w_next;
          r_work        <= w_next;
          r_round       <= r_round + IDX_WIDTH'(1);
          r_rcon        <= xtime(r_rcon);
          if (r_round == LAST_ROUND) r_done <= 1'b1;
        end
        default: ;
      endcase
      if (rk_idx <= LAST_ROUND) r_rkOut <= r_rk[rk_idx];
      else                      r_rkOut <= '0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule against a byte-level FIPS-197 key expansion model.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .keys_valid(keys_valid),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out)
  );

  int checks     = 0;
  int failures   = 0;
  int cycleCnt   = 0;
  int donePulses = 0;
  int doneExpected = 0;

  logic rdReq  = 1'b0;
  logic rdReqD = 1'b0;
  logic [127:0] rdQ[$];
  int doneQ[$];

  logic [7:0]   sboxTbl [256];
  logic [7:0]   wb [44][4];
  logic [127:0] mdl [11];
  logic [7:0]   rconTbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always @(posedge clk) cycleCnt <= cycleCnt + 1;
  always @(posedge clk) rdReqD <= rdReq;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = h[127-8*k -: 8];
    return r;
  endfunction

  task automatic computeModel(input logic [127:0] key);
    logic [7:0] t [4];
    logic [7:0] tmp;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) wb[i][j] = key[8*(4*i+j) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = wb[i-1][j];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sboxTbl[t[1]] ^ rconTbl[i/4-1];
        t[1] = sboxTbl[t[2]];
        t[2] = sboxTbl[t[3]];
        t[3] = sboxTbl[tmp];
      end
      for (int j = 0; j < 4; j++) wb[i][j] = wb[i-4][j] ^ t[j];
    end
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) mdl[r][8*(4*c+j) +: 8] = wb[4*r+c][j];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a key until accepted; the expected done edge goes to the scoreboard
  task automatic applyStimulus(input logic [127:0] key, input bit hold, output int hsEdge);
    bit acc;
    key_in    = key;
    key_valid = 1'b1;
    hsEdge    = -1;
    for (int n = 0; n < 40; n++) begin
      acc = key_ready;
      tick();
      if (acc) begin
        hsEdge = cycleCnt;
        break;
      end
    end
    if (!hold) key_valid = 1'b0;
    checkOutput("handshake accepted", 128'(hsEdge >= 0), 128'd1);
    if (hsEdge >= 0) begin
      doneQ.push_back(hsEdge + 10);
      doneExpected++;
    end
  endtask

  task automatic waitKeysValid();
    for (int n = 0; n < 30; n++) begin
      if (keys_valid) break;
      tick();
    end
    checkOutput("keys_valid reached", 128'(keys_valid), 128'd1);
  endtask

  task automatic readIdx(input int idx, input logic [127:0] exp);
    rk_idx = 4'(idx);
    rdReq  = 1'b1;
    rdQ.push_back(exp);
    tick();
    rdReq = 1'b0;
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) readIdx(i, (i <= 10) ? mdl[i] : 128'h0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " key_ready"},  128'(key_ready),  128'd1);
    checkOutput({tag, " busy"},       128'(busy),       128'd0);
    checkOutput({tag, " done"},       128'(done),       128'd0);
    checkOutput({tag, " keys_valid"}, 128'(keys_valid), 128'd0);
    checkOutput({tag, " rk_out"},     rk_out,           128'h0);
  endtask

  // Monitor: compares registered reads and done pulses against queued expectations
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdReqD) begin
        if (rdQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL read scoreboard: actual=read without expectation required=none");
        end else checkOutput("rk_out read", rk_out, rdQ.pop_front());
      end
      if (done) begin
        donePulses++;
        if (doneQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL done unexpected: actual=1 at cycle %0d required=0", cycleCnt);
        end else checkOutput("done cycle", 128'(cycleCnt), 128'(doneQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2047:0] sboxVec;
    logic [127:0] keyA, keyB;
    int e1, e2;

    sboxVec = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
               128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
               128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
               128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
               128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
               128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
               128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
               128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sboxTbl[i] = sboxVec[2047-8*i -: 8];

    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_idx = '0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] FIPS-197 A.1 key");
    computeModel(fips(128'h2b7e151628aed2a6abf7158809cf4f3c));
    applyStimulus(fips(128'h2b7e151628aed2a6abf7158809cf4f3c), 1'b0, e1);
    checkOutput("busy after handshake", 128'(busy), 128'd1);
    checkOutput("key_ready in expand", 128'(key_ready), 128'd0);
    waitKeysValid();
    sweep();
    readIdx(1,  fips(128'ha0fafe1788542cb123a339392a6c7605));
    readIdx(10, fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    $display("[TB] all-zero key");
    computeModel(128'h0);
    applyStimulus(128'h0, 1'b0, e1);
    waitKeysValid();
    readIdx(1,  fips(128'h62636363626363636263636362636363));
    readIdx(10, fips(128'hb4ef5bcb3e92e21123e951cf6f8f188e));
    sweep();

    $display("[TB] random keys");
    repeat (4) begin
      keyA = {$urandom(), $urandom(), $urandom(), $urandom()};
      computeModel(keyA);
      applyStimulus(keyA, 1'b0, e1);
      waitKeysValid();
      sweep();
    end

    $display("[TB] reset during expansion");
    keyA = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(keyA, 1'b0, e1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid reset");
    doneQ.delete();
    doneExpected--;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    readIdx(10, 128'h0);
    readIdx(0, 128'h0);
    keyA = {$urandom(), $urandom(), $urandom(), $urandom()};
    computeModel(keyA);
    applyStimulus(keyA, 1'b0, e1);
    waitKeysValid();
    readIdx(10, mdl[10]);
    readIdx(1, mdl[1]);

    $display("[TB] key_valid during expansion");
    keyA = {$urandom(), $urandom(), $urandom(), $urandom()};
    keyB = {$urandom(), $urandom(), $urandom(), $urandom()};
    computeModel(keyA);
    applyStimulus(keyA, 1'b0, e1);
    tick(); tick();
    key_in = keyB;
    key_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      checkOutput("key_ready ignored key", 128'(key_ready), 128'd0);
      tick();
    end
    key_valid = 1'b0;
    waitKeysValid();
    sweep();
    computeModel(keyB);
    applyStimulus(keyB, 1'b0, e1);
    checkOutput("keys_valid drop", 128'(keys_valid), 128'd0);
    checkOutput("busy on rekey", 128'(busy), 128'd1);
    waitKeysValid();
    sweep();

    $display("[TB] back-to-back keys");
    keyA = {$urandom(), $urandom(), $urandom(), $urandom()};
    keyB = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(keyA, 1'b1, e1);
    key_in = keyB;
    for (int n = 0; n < 30; n++) begin
      if (key_ready) break;
      tick();
    end
    checkOutput("b2b ready reached", 128'(key_ready), 128'd1);
    checkOutput("b2b first READY cycle", 128'(cycleCnt), 128'(e1 + 10));
    rk_idx = 4'd0;
    rdReq  = 1'b1;
    rdQ.push_back(keyA);
    applyStimulus(keyB, 1'b0, e2);
    rdReq = 1'b0;
    checkOutput("b2b handshake edge", 128'(e2), 128'(e1 + 11));
    computeModel(keyB);
    waitKeysValid();
    sweep();

    tick(); tick();
    checkOutput("read queue drained", 128'(rdQ.size()), 128'd0);
    checkOutput("done pulse count", 128'(donePulses), 128'(doneExpected));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Sequential AES-128 key scheduler.
- Accepts a 128-bit cipher key over a valid/ready handshake and computes round keys 1..10, one per clock, by iterating a single-round key transform with Rcon.
- Stores all 11 round keys (0..10) and serves them to the cipher round datapath through a registered indexed read port.
- Sits directly downstream of key loading and upstream of AddRoundKey.

Parameters:
- DATA_WIDTH, 128, key / round-key width in bits (only 128 supported).
- NUM_ROUNDS, 10, number of expansion rounds; 11 keys stored.
- IDX_WIDTH, 4, width of the round-key index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  cipher key offered on key_in.
- key_ready  out  1  scheduler can accept a key.
- key_in  in  DATA_WIDTH  cipher key; FIPS byte k at bits [8k+7:8k]; column c = bits [32c+31:32c].
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when round key 10 has been written.
- keys_valid  out  1  all 11 round keys are valid.
- rk_idx  in  IDX_WIDTH  round-key index to read, 0..10.
- rk_out  out  DATA_WIDTH  registered round key for the index sampled on the previous edge.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; key_ready=1; busy=0; done=0; keys_valid=0; rk_out=0; round counter=0; rcon=8'h01; all key storage cleared to 0. Reset mid-expansion aborts immediately to this state.
- FSM states: IDLE, EXPAND, READY.
  - IDLE: key_ready=1. On key_valid&&key_ready: rk[0] and work register <= key_in; round<=1; rcon<=8'h01; go to EXPAND.
  - EXPAND: key_ready=0, busy=1, keys_valid=0.
    - Each edge computes next = key_round(work, rcon), then rk[round] <= next, work <= next, round <= round+1, rcon <= xtime(rcon).
    - xtime: shift left by 1; XOR 8'h1b if the MSB was set.
    - When round==NUM_ROUNDS on that edge: go to READY and assert done for the following cycle only.
  - READY: keys_valid=1, key_ready=1, busy=0. A new key_valid handshake behaves as in IDLE: keys_valid drops on the next edge and rk[0] is overwritten.
  - key_valid during EXPAND is ignored. The source must hold the key until the handshake completes.
- Latency: handshake accepted at edge 0; rk[i] written at edge i; rk[10] written at edge 10; done and keys_valid high after edge 10.
- Rcon sequence over rounds 1..10: 01 02 04 08 10 20 40 80 1b 36.
- key_round (combinational), for input columns w0..w3:
  - t = SubWord(RotWord(w3)). RotWord: byte order {b1,b2,b3,b0} with byte 0 in the LSB, i.e. the result's byte 0 is b1.
  - t[7:0] ^= rcon.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Output is {w3',w2',w1',w0'}.
- Read port: rk_out <= rk[rk_idx] on every edge, giving 1-cycle latency.
  - rk_idx>10 returns 0.
  - Reads are allowed in any state. Content is guaranteed only while keys_valid=1.
  - Reading the index being written on the same edge returns the old value.
- Handshake accepted on the same edge as reset deassertion: ignored (reset wins).

Decomposition:
- Package aes_pkg holds:
  - NUM_ROUNDS=10 and AES_BYTE=8.
  - typedef ks_state_t enum {IDLE, EXPAND, READY}.
  - function xtime(byte).
  - typedef word_t logic[31:0].
- Sub-module key_round: combinational single-round transform with rcon input, built from four s_box instances.
- The top holds the FSM, counter, rcon register, 11-entry key storage and read register.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c (bytes in order):
  - done pulses 10 cycles after the handshake.
  - rk[1] = a0fafe1788542cb123a339392a6c7605.
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rk[1] = 62636363626363636263636362636363.
  - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- Sweep rk_idx 0..15 after keys_valid:
  - Indices 0..10 return the stored keys one cycle later.
  - Indices 11..15 return 0.
- Assert rst_n=0 at expansion round 5: outputs return immediately to reset values. A new key then completes normally with correct rk[10].
- Toggle key_valid with a different key during EXPAND:
  - The new key is ignored and key_ready stays 0.
  - A second handshake in READY drops keys_valid on the next edge and regenerates keys for the new key.
- Back-to-back keys:
  - Hold key_valid high across READY.
  - The handshake completes in the first READY cycle.
  - done pulses once per key.
